// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and system reset release
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int CNT_WIDTH           = 8
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 force_relock,
    output logic                 pll_rst,
    output logic                 sys_reset,
    output logic                 lock_ok,
    output logic [CNT_WIDTH-1:0] retry_count,
    output logic [CNT_WIDTH-1:0] loss_count
);

    localparam int MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_C = (LOCK_TIMEOUT_CYCLES > MAX_A) ? LOCK_TIMEOUT_CYCLES : MAX_A;
    localparam int TW    = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] cnt, cnt_n;
    logic          sync1, lk;
    logic          retry_inc, loss_inc;

    // pll_locked is asynchronous to refclk
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk    <= sync1;
        end
    end

    always_comb begin
        state_n   = state;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state)
            RESET_PLL: begin
                if (cnt == TW'(RST_PULSE_CYCLES - 1))
                    state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (force_relock)
                    state_n = RESET_PLL;
                else if (lk)
                    state_n = STABLE;
                else if (cnt == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_n   = RESET_PLL;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (force_relock)
                    state_n = RESET_PLL;
                else if (!lk)
                    state_n = WAIT_LOCK;
                else if (cnt == TW'(LOCK_STABLE_CYCLES - 1))
                    state_n = RUN;
            end
            RUN: begin
                // a loss coinciding with force_relock is still recorded as a loss
                if (!lk) begin
                    state_n  = RESET_PLL;
                    loss_inc = 1'b1;
                end else if (force_relock)
                    state_n = RESET_PLL;
            end
            default: state_n = RESET_PLL;
        endcase

        if (state_n != state || state == RUN)
            cnt_n = '0;
        else
            cnt_n = cnt + 1'b1;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_reset   <= 1'b1;
            lock_ok     <= 1'b0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pll_rst   <= (state_n == RESET_PLL);
            sys_reset <= (state_n != RUN);
            lock_ok   <= (state_n == RUN);
            if (retry_inc && retry_count != '1)
                retry_count <= retry_count + 1'b1;
            if (loss_inc && loss_count != '1)
                loss_count <= loss_count + 1'b1;
        end
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises the system PLL from its reference clock: pulses the PLL reset, waits for lock, qualifies it, then releases the system reset.
- Detects loss of lock and relock timeouts, and retries automatically. Counts both events for NIOS status readout.
- Sits between the board 50 MHz clock/reset pins and the PLL wrapper's rst/locked pins. Runs on refclk because PLL outputs are invalid while unlocked.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles pll_rst is held high per reset attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 50000: refclk cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release.
- CNT_WIDTH, 8: width of the retry and loss counters.

Ports:
- refclk  in  1  reference clock, 50 MHz; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL locked, asynchronous to refclk.
- force_relock  in  1  single-cycle software request to re-reset the PLL.
- pll_rst  out  1  active-high reset to PLL, registered.
- sys_reset  out  1  active-high system reset, registered.
- lock_ok  out  1  high only in RUN.
- retry_count  out  CNT_WIDTH  number of WAIT_LOCK timeouts, saturating.
- loss_count  out  CNT_WIDTH  number of lock losses in RUN, saturating.

Behaviour:
- Reset values while rst is high:
  - state=RESET_PLL; pll_rst=1, sys_reset=1, lock_ok=0.
  - retry_count=0, loss_count=0; internal counters and synchronizer flops 0.
- Synchronizer: pll_locked passes through a 2-flop synchronizer to give lk. Latency is 2 refclk edges; every decision below uses lk.
- All outputs are registered and reflect the current state. On entering a state the cycle counter clears to 0.
- RESET_PLL:
  - pll_rst=1, sys_reset=1.
  - After RST_PULSE_CYCLES cycles in the state, go to WAIT_LOCK, so pll_rst is high for exactly RST_PULSE_CYCLES cycles.
  - lk and force_relock are ignored here.
- WAIT_LOCK:
  - pll_rst=0, sys_reset=1.
  - lk=1 -> STABLE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT_CYCLES-1: retry_count+1 (saturating), go to RESET_PLL.
  - force_relock=1 -> RESET_PLL with no retry increment. It takes priority over lk and timeout.
- STABLE:
  - pll_rst=0, sys_reset=1.
  - lk=0 -> WAIT_LOCK; the timeout counter restarts and no counter increments.
  - LOCK_STABLE_CYCLES consecutive lk=1 cycles -> RUN.
  - force_relock -> RESET_PLL.
- RUN:
  - pll_rst=0, sys_reset=0, lock_ok=1.
  - lk=0 -> loss_count+1 (saturating) and go to RESET_PLL. sys_reset re-asserts on the next edge, i.e. 3 edges after pll_locked falls.
  - force_relock -> RESET_PLL with no loss increment.
  - lk=0 together with force_relock -> counts as a loss (loss increment wins).
- Counters: both stick at 2^CNT_WIDTH-1 and never wrap. They clear only on rst.
- Glitches: a pll_locked glitch shorter than one refclk period may or may not be captured. If captured in RUN it is a loss.
- rst asserted in any state returns immediately (asynchronously) to the reset values, including the counters.
- rst deassertion: the first state advance occurs on the first refclk edge after release.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, CNT_WIDTH=3.
- Clean bring-up: release rst, raise pll_locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_reset falls and lock_ok rises 2+8 cycles after pll_locked rises (+1 to enter STABLE); both counts 0.
- Timeout retry: hold pll_locked=0 -> pll_rst re-pulses 4 cycles every 24 cycles. After 9 timeouts retry_count=7 (saturated, no wrap).
- Unstable lock: pll_locked high 5 cycles, low 1, high -> return to WAIT_LOCK, no RUN entry; RUN is reached only after 8 uninterrupted cycles; retry_count unchanged.
- Loss in RUN: drop pll_locked in RUN -> sys_reset=1 and lock_ok=0 exactly 3 edges later; loss_count=1; pll_rst pulses 4 cycles; relock resumes.
- force_relock in RUN, then force_relock coincident with lk falling -> first gives loss_count unchanged and pll_rst pulse; second gives loss_count+1.
- Async reset mid-STABLE: assert rst between edges -> pll_rst=1, sys_reset=1, counters 0 before the next edge.
